// File: rtl/ifm_pingpong_pkg.sv
// Shared types for the IFM ping-pong buffer controller and its per-part trackers.
package ifm_pingpong_pkg;

    localparam int NUM_PARTS = 2;

    typedef enum logic [1:0] {
        PART_EMPTY,
        PART_LOADING,
        PART_FULL,
        PART_READING
    } part_state_e;

    typedef enum logic [1:0] {
        C_WAIT,
        C_RUN,
        C_SWITCH
    } cons_state_e;

    typedef enum logic {
        T_IDLE,
        T_RUN
    } top_state_e;

endpackage

// File: rtl/ifm_part_state.sv
// Occupancy tracker for one half of the double-buffered IFM store.
//   state        | meaning
//   PART_EMPTY   | free, may be handed to the loader
//   PART_LOADING | loader has accepted a fill into this part
//   PART_FULL    | fill complete, waiting for the img2col pair
//   PART_READING | img2col pair consuming this part
module ifm_part_state
    import ifm_pingpong_pkg::*;
(
    input  logic        clock,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load_ack,
    input  logic        load_done,
    input  logic        rd_start,
    input  logic        rd_free,
    output part_state_e state
);

    part_state_e state_q, state_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PART_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = PART_EMPTY;
        end else begin
            case (state_q)
                PART_EMPTY:   if (load_ack)  state_d = PART_LOADING;
                PART_LOADING: if (load_done) state_d = PART_FULL;
                PART_FULL:    if (rd_start)  state_d = PART_READING;
                PART_READING: if (rd_free)   state_d = PART_EMPTY;
                default:                     state_d = PART_EMPTY;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/ifm_pingpong_ctrl.sv
// Schedules loader fills into alternating IFM parts and hands full parts to the img2col pair,
// keeping the bridge read selection (buf_switch / loop_end) in step with the consumed part.
//   state    | meaning
//   T_IDLE   | no layer active, waiting for start
//   T_RUN    | layer in progress
//   C_WAIT   | waiting for part[cons_sel] to become FULL
//   C_RUN    | img2col pair working, collecting both done strobes
//   C_SWITCH | release part, advance or end the layer (1 cycle)
module ifm_pingpong_ctrl
    import ifm_pingpong_pkg::*;
#(
    parameter int TILE_W = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    output logic              busy,
    output logic              layer_done,
    output logic              load_req,
    output logic              load_part,
    input  logic              load_ack,
    input  logic              load_done,
    output logic              i2c_start,
    input  logic              i2c_done_0,
    input  logic              i2c_done_1,
    output logic              buf_switch,
    output logic              loop_end
);

    top_state_e        top_q, top_d;
    cons_state_e       cons_q, cons_d;
    logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
    logic [TILE_W-1:0] loaded_cnt_q, loaded_cnt_d;
    logic [TILE_W-1:0] consumed_cnt_q, consumed_cnt_d;
    logic              load_sel_q, load_sel_d;
    logic              cons_sel_q, cons_sel_d;
    logic              d0_q, d0_d;
    logic              d1_q, d1_d;
    logic              busy_q, busy_d;
    logic              layer_done_q, layer_done_d;
    logic              load_req_q, load_req_d;
    logic              i2c_start_q, i2c_start_d;
    logic              buf_switch_q, buf_switch_d;
    logic              loop_end_q, loop_end_d;

    part_state_e          part_st [NUM_PARTS];
    logic [NUM_PARTS-1:0] ack_stb, done_stb, rd_start, rd_free, part_free;
    logic                 part_clr, any_loading;

    assign ack_stb[0]  = load_req_q & load_ack & ~load_sel_q;
    assign ack_stb[1]  = load_req_q & load_ack &  load_sel_q;
    assign done_stb[0] = load_done & (part_st[0] == PART_LOADING);
    assign done_stb[1] = load_done & (part_st[1] == PART_LOADING);
    assign any_loading = (part_st[0] == PART_LOADING) || (part_st[1] == PART_LOADING);

    ifm_part_state u_part0 (
        .clock     (clock),
        .rst_n     (rst_n),
        .clr       (part_clr),
        .load_ack  (ack_stb[0]),
        .load_done (done_stb[0]),
        .rd_start  (rd_start[0]),
        .rd_free   (rd_free[0]),
        .state     (part_st[0])
    );

    ifm_part_state u_part1 (
        .clock     (clock),
        .rst_n     (rst_n),
        .clr       (part_clr),
        .load_ack  (ack_stb[1]),
        .load_done (done_stb[1]),
        .rd_start  (rd_start[1]),
        .rd_free   (rd_free[1]),
        .state     (part_st[1])
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            top_q          <= T_IDLE;
            cons_q         <= C_WAIT;
            num_tiles_q    <= '0;
            loaded_cnt_q   <= '0;
            consumed_cnt_q <= '0;
            load_sel_q     <= 1'b0;
            cons_sel_q     <= 1'b0;
            d0_q           <= 1'b0;
            d1_q           <= 1'b0;
            busy_q         <= 1'b0;
            layer_done_q   <= 1'b0;
            load_req_q     <= 1'b0;
            i2c_start_q    <= 1'b0;
            buf_switch_q   <= 1'b0;
            loop_end_q     <= 1'b0;
        end else begin
            top_q          <= top_d;
            cons_q         <= cons_d;
            num_tiles_q    <= num_tiles_d;
            loaded_cnt_q   <= loaded_cnt_d;
            consumed_cnt_q <= consumed_cnt_d;
            load_sel_q     <= load_sel_d;
            cons_sel_q     <= cons_sel_d;
            d0_q           <= d0_d;
            d1_q           <= d1_d;
            busy_q         <= busy_d;
            layer_done_q   <= layer_done_d;
            load_req_q     <= load_req_d;
            i2c_start_q    <= i2c_start_d;
            buf_switch_q   <= buf_switch_d;
            loop_end_q     <= loop_end_d;
        end
    end

    always_comb begin
        top_d          = top_q;
        cons_d         = cons_q;
        num_tiles_d    = num_tiles_q;
        loaded_cnt_d   = loaded_cnt_q;
        consumed_cnt_d = consumed_cnt_q;
        load_sel_d     = load_sel_q;
        cons_sel_d     = cons_sel_q;
        d0_d           = d0_q;
        d1_d           = d1_q;
        load_req_d     = load_req_q;
        i2c_start_d    = 1'b0;
        buf_switch_d   = 1'b0;
        loop_end_d     = 1'b0;
        layer_done_d   = 1'b0;
        rd_start       = '0;
        rd_free        = '0;
        part_free      = '0;
        part_clr       = 1'b0;

        case (top_q)
            T_IDLE: begin
                if (start) begin
                    top_d          = T_RUN;
                    cons_d         = C_WAIT;
                    num_tiles_d    = num_tiles;
                    loaded_cnt_d   = '0;
                    consumed_cnt_d = '0;
                    load_sel_d     = 1'b0;
                    cons_sel_d     = 1'b0;
                    d0_d           = 1'b0;
                    d1_d           = 1'b0;
                    part_clr       = 1'b1;
                    // Parts are cleared here, so the first request can go out next cycle.
                    load_req_d     = (num_tiles != '0);
                    loop_end_d     = (num_tiles == '0);
                    layer_done_d   = (num_tiles == '0);
                end
            end
            T_RUN: begin
                if (layer_done_q) top_d = T_IDLE;

                case (cons_q)
                    C_WAIT: begin
                        if (part_st[cons_sel_q] == PART_FULL) begin
                            i2c_start_d          = 1'b1;
                            rd_start[cons_sel_q] = 1'b1;
                            cons_d               = C_RUN;
                        end
                    end
                    C_RUN: begin
                        d0_d = d0_q | i2c_done_0;
                        d1_d = d1_q | i2c_done_1;
                        if (d0_q && d1_q) begin
                            cons_d = C_SWITCH;
                            if (consumed_cnt_q == num_tiles_q - TILE_W'(1)) begin
                                loop_end_d   = 1'b1;
                                layer_done_d = 1'b1;
                            end else begin
                                buf_switch_d = 1'b1;
                            end
                        end
                    end
                    C_SWITCH: begin
                        rd_free[cons_sel_q] = 1'b1;
                        d0_d                = 1'b0;
                        d1_d                = 1'b0;
                        consumed_cnt_d      = consumed_cnt_q + TILE_W'(1);
                        // Mirror the bridge: loop_end forces part 0, buf_switch toggles.
                        cons_sel_d          = buf_switch_q ? ~cons_sel_q : 1'b0;
                        cons_d              = C_WAIT;
                    end
                    default: cons_d = C_WAIT;
                endcase

                // A part being freed this cycle counts as empty so its refill is not delayed.
                part_free[0] = (part_st[0] == PART_EMPTY) || rd_free[0];
                part_free[1] = (part_st[1] == PART_EMPTY) || rd_free[1];

                if (load_req_q) begin
                    if (load_ack) load_req_d = 1'b0;
                end else if (!any_loading && part_free[load_sel_q] &&
                             (loaded_cnt_q < num_tiles_q)) begin
                    load_req_d = 1'b1;
                end

                if (|done_stb) begin
                    loaded_cnt_d = loaded_cnt_q + TILE_W'(1);
                    load_sel_d   = ~load_sel_q;
                end
            end
            default: top_d = T_IDLE;
        endcase

        busy_d = (top_d == T_RUN);
    end

    assign busy       = busy_q;
    assign layer_done = layer_done_q;
    assign load_req   = load_req_q;
    assign load_part  = load_sel_q;
    assign i2c_start  = i2c_start_q;
    assign buf_switch = buf_switch_q;
    assign loop_end   = loop_end_q;

endmodule
